// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if
//   Host-side character handshake for uart_tx_cfg, plus the per-frame format
//   controls. The format controls travel with the character because the
//   transmitter samples them on the same edge as in_data.
//
//   Signals
//     in_valid  source -> tx   character available
//     in_ready  tx -> source   transmitter idle, will take a character
//     in_data   source -> tx   character, DATA_BITS wide
//     par_mode  source -> tx   00 none, 01 odd, 10 even, 11 none
//     stop2     source -> tx   0: one stop bit, 1: two stop bits
//
//   Modports
//     master  the byte source (FIFO / CPU registers)
//     slave   the transmitter
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_BITS-1:0] in_data;
    logic [1:0]           par_mode;
    logic                 stop2;

    modport master (
        output in_valid,
        output in_data,
        output par_mode,
        output stop2,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  par_mode,
        input  stop2,
        output in_ready
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
//   Runtime-configurable UART transmitter. One character per valid/ready
//   transfer is sent as: start bit, DATA_BITS data bits LSB first, optional
//   odd/even parity bit, then one or two stop bits. Each bit lasts OVERSAMPLE
//   pulses of the shared tick_baud strobe.
//
//   Ports
//     clk        system clock, all logic on posedge
//     rst_n      asynchronous active-low reset
//     tick_baud  one-cycle oversampling strobe, OVERSAMPLE per bit
//     in_if      slave side of the character handshake (data + format)
//     tx         serial line, idle high, registered
//     busy       frame in progress
//     tx_done    one-cycle pulse as the last stop bit ends
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_baud,
    uart_tx_cfg_if.slave  in_if,
    output logic          tx,
    output logic          busy,
    output logic          tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (OVERSAMPLE < 2) begin : g_bad_oversample
        $error("uart_tx_cfg: OVERSAMPLE must be at least 2");
    end

    localparam int               TCW       = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0]   TICK_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q,    state_d;
    logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [3:0]           bit_cnt_q,  bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 use_par_q,  use_par_d;
    logic                 par_bit_q,  par_bit_d;
    logic                 stop2_q,    stop2_d;
    logic                 tx_q,       tx_d;
    logic                 tx_done_q,  tx_done_d;

    logic xfer;
    logic bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            use_par_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            use_par_q  <= use_par_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        use_par_d  = use_par_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        tx_done_d  = 1'b0;
        tx_d       = 1'b1;

        xfer    = in_if.in_valid && (state_q == S_IDLE);
        bit_end = tick_baud && (tick_cnt_q == TICK_LAST);

        // The tick counter only runs inside a frame, so a tick arriving in
        // the same cycle as the transfer never shortens the start bit.
        if (state_q != S_IDLE && tick_baud) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                if (xfer) begin
                    state_d   = S_START;
                    shift_d   = in_if.in_data;
                    stop2_d   = in_if.stop2;
                    use_par_d = (in_if.par_mode == 2'b01) || (in_if.par_mode == 2'b10);
                    // Parity is fixed at capture because the shift register
                    // is consumed while the data bits go out.
                    par_bit_d = (in_if.par_mode == 2'b10) ? (^in_if.in_data)
                                                          : (~^in_if.in_data);
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d    = use_par_q ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        tx_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
            end
        endcase

        // tx is registered from the next state so the line changes on the
        // same edge as the state that owns the bit.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx             = tx_q;
    assign tx_done        = tx_done_q;
    assign busy           = (state_q != S_IDLE);
    assign in_if.in_ready = (state_q == S_IDLE);

endmodule
